urcpu_operand_loader: RTL and testbench

Sequencer that sits directly upstream of the UrCPU add program and closes the loop around it. It accepts operand words on a valid/ready stream and writes them into the shared 256×32 data memory at consecutive addresses, then pulses the CPU stage to run. It waits for completion, or for a timeout, then reads the result word back and presents it on an output valid/ready stream. It repeats indefinitely: one transaction per operand set.

---
 rtl/urcpu_operand_loader.sv | 153 +++++++++++++++
 tb/tb_urcpu_operand_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/urcpu_operand_loader.sv
// Operand loader for the UrCPU add program: streams operand words into data memory,
// starts the CPU stage, waits for done or timeout, then returns the result word.
module urcpu_operand_loader #(
  parameter int unsigned         ADDR_W      = 8,
  parameter int unsigned         DATA_W      = 32,
  parameter logic [ADDR_W-1:0]   LOAD_BASE   = 8'hF0,
  parameter int unsigned         LOAD_COUNT  = 2,
  parameter logic [ADDR_W-1:0]   RESULT_ADDR = 8'hF2,
  parameter int unsigned         TIMEOUT     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned       IDX_W    = 5;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LOAD_COUNT - 1);
  localparam logic [15:0]       TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_OUT
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [15:0]         cnt_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                cpu_start_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_err_q;
  logic                busy_q;

  logic in_hs;
  assign in_hs = in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a non-blocking default here and are overridden
      // below; the last non-blocking write in the block wins, so no ordering hazard.
      mem_we_q    <= 1'b0;
      cpu_start_q <= 1'b0;

      case (state_q)
        S_LOAD: begin
          if (in_hs) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= LOAD_BASE + ADDR_W'(idx_q);
            mem_wdata_q <= in_data;
            busy_q      <= 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              in_ready_q  <= 1'b0;
              cpu_start_q <= 1'b1;
              state_q     <= S_START;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (cpu_done) begin
            // Address goes out on entry to READ so the read data lands during CAPT.
            mem_addr_q <= RESULT_ADDR;
            state_q    <= S_READ;
          end else if (cnt_q == TO_LAST) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end

        S_READ: begin
          state_q <= S_CAPT;
        end

        S_CAPT: begin
          out_data_q  <= mem_rdata;
          out_err_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            state_q     <= S_LOAD;
          end
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_start = cpu_start_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_urcpu_operand_loader.sv
// Scoreboard bench for urcpu_operand_loader: a memory/CPU model plus write and
// result monitors that pop expected values queued by the directed stimulus.
module tb_urcpu_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, mem_we, cpu_start, cpu_done;
  logic        out_valid, out_ready, out_err, busy;
  logic [31:0] in_data, mem_wdata, mem_rdata, out_data;
  logic [7:0]  mem_addr;

  logic        w_in_valid, w_in_ready, w_mem_we, w_cpu_start, w_cpu_done;
  logic        w_out_valid, w_out_ready, w_out_err, w_busy;
  logic [31:0] w_in_data, w_mem_wdata, w_mem_rdata, w_out_data;
  logic [7:0]  w_mem_addr;

  urcpu_operand_loader #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  urcpu_operand_loader #(.LOAD_BASE(8'hFF), .LOAD_COUNT(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
    .cpu_start(w_cpu_start), .cpu_done(w_cpu_done),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_err(w_out_err), .busy(w_busy)
  );

  assign w_mem_rdata = 32'h0;
  assign w_cpu_done  = 1'b0;
  assign w_out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory and CPU model: synchronous read, CPU result written at RESULT_ADDR.
  logic [31:0] mem [256];
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (cpu_wr) mem[8'hF2] <= cpu_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic err; logic [31:0] data; } res_t;
  wr_t  wq[$];
  res_t oq[$];
  wr_t  wr_exp;
  res_t res_exp;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: write 0x%0h @0x%0h, none expected", mem_wdata, mem_addr);
      end else begin
        wr_exp = wq.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(wr_exp.addr));
        check("wr_data", mem_wdata, wr_exp.data);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (oq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: result 0x%0h err %0b, none expected", out_data, out_err);
      end else begin
        res_exp = oq.pop_front();
        check("out_data", out_data, res_exp.data);
        check("out_err", 32'(out_err), 32'(res_exp.err));
      end
    end
  end

  logic rd_watch;
  int   rd_seen;
  always @(negedge clk) begin
    if (rd_watch && !mem_we && mem_addr == 8'hF2) rd_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] a);
    in_valid = 1'b1;
    in_data  = d;
    wq.push_back('{addr: a, data: d});
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic cpu_finish(input int d_cycles);
    repeat (d_cycles) tick();
    cpu_wdata = mem[8'hF0] + mem[8'hF1];
    cpu_wr    = 1'b1;
    cpu_done  = 1'b1;
    tick();
    cpu_wr    = 1'b0;
    cpu_done  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 2000) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: no out_valid within %0d cycles", n);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ov_seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cpu_done = 1'b0; cpu_wr = 1'b0;
    cpu_wdata = '0; out_ready = 1'b1; rd_watch = 1'b0; rd_seen = 0;
    w_in_valid = 1'b0; w_in_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Wrap: writes at FF then 00.
    w_in_valid = 1'b1; w_in_data = 32'hAAAA_0001;
    tick();
    check("wrap_we0", 32'(w_mem_we), 32'd1);
    check("wrap_addr0", 32'(w_mem_addr), 32'hFF);
    check("wrap_data0", w_mem_wdata, 32'hAAAA_0001);
    w_in_data = 32'hAAAA_0002;
    tick();
    w_in_valid = 1'b0;
    check("wrap_addr1", 32'(w_mem_addr), 32'h00);
    check("wrap_data1", w_mem_wdata, 32'hAAAA_0002);
    check("wrap_start", 32'(w_cpu_start), 32'd1);
    tick();
    check("wrap_we_off", 32'(w_mem_we), 32'd0);

    // Normal add 5 + 7.
    send(32'd5, 8'hF0);
    check("add_busy", 32'(busy), 32'd1);
    check("add_no_start_early", 32'(cpu_start), 32'd0);
    send(32'd7, 8'hF1);
    check("add_start", 32'(cpu_start), 32'd1);
    check("add_last_write_addr", 32'(mem_addr), 32'hF1);
    check("add_in_ready_low", 32'(in_ready), 32'd0);
    oq.push_back('{err: 1'b0, data: 32'd12});
    tick();
    check("add_start_one_cycle", 32'(cpu_start), 32'd0);
    cpu_finish(2);
    wait_valid(n);
    check("add_done_to_valid", n, 2);
    tick();
    check("add_back_to_load", 32'(in_ready), 32'd1);
    check("add_idle_busy", 32'(busy), 32'd0);

    // Input gaps: in_valid 1,0,0,1.
    send(32'h11, 8'hF0);
    tick();
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_ready", 32'(in_ready), 32'd1);
    tick();
    send(32'h22, 8'hF1);
    check("gap_ready_low", 32'(in_ready), 32'd0);
    oq.push_back('{err: 1'b0, data: 32'h33});
    cpu_finish(1);
    wait_valid(n);
    tick();

    // Timeout with stray cpu_done in LOAD ignored.
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("stray_done_ready", 32'(in_ready), 32'd1);
    check("stray_done_busy", 32'(busy), 32'd0);
    send(32'd1, 8'hF0);
    send(32'd2, 8'hF1);
    rd_watch = 1'b1;
    rd_seen  = 0;
    oq.push_back('{err: 1'b1, data: 32'd0});
    wait_valid(n);
    check("timeout_latency", n, 9);
    tick();
    rd_watch = 1'b0;
    check("timeout_no_read", rd_seen, 0);

    // Output backpressure, then 0xFFFFFFFF + 1.
    out_ready = 1'b0;
    send(32'd3, 8'hF0);
    send(32'd4, 8'hF1);
    oq.push_back('{err: 1'b0, data: 32'd7});
    cpu_finish(2);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(in_ready), 32'd1);
    send(32'hFFFF_FFFF, 8'hF0);
    send(32'h1, 8'hF1);
    oq.push_back('{err: 1'b0, data: 32'd0});
    cpu_finish(2);
    wait_valid(n);
    tick();

    // Reset during WAIT, then a late cpu_done.
    send(32'd8, 8'hF0);
    send(32'd9, 8'hF1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || cpu_start) ov_seen++;
      tick();
    end
    check("midrst_no_output", ov_seen, 0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);

    check("writes_drained", wq.size(), 0);
    check("results_drained", oq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
